// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared types and sizing helper for the reset sequencer
package rst_seq_pkg;

  typedef enum logic [2:0] {
    HOLD,
    WAIT_ACK,
    GAP,
    RUN,
    FAULT
  } seq_state_t;

  // Bits needed to count up to the largest of the three limits without wrapping.
  function automatic int clog2_max(input int a, input int b, input int c);
    int m;
    int w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    m = m + 1;
    w = 0;
    while ((1 << w) < m) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// rtl/rst_sequencer_if.sv - request/ack and reset-output bundle of the reset sequencer
interface rst_sequencer_if #(
  parameter int NUM_CH = 3
);

  logic              SoftRstReq;
  logic [NUM_CH-1:0] ChReady;
  logic [NUM_CH-1:0] ChRst;
  logic              Done;
  logic              Fault;
  logic [3:0]        FaultCh;

  modport master (
    input  SoftRstReq,
    input  ChReady,
    output ChRst,
    output Done,
    output Fault,
    output FaultCh
  );

  modport slave (
    output SoftRstReq,
    output ChReady,
    input  ChRst,
    input  Done,
    input  Fault,
    input  FaultCh
  );

endinterface

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - releases NUM_CH reset domains in order, waiting for each ready ack
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH         = 3,
  parameter int HOLD_CYCLES    = 4,
  parameter int STAGGER_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 8
) (
  input logic              Clk,
  input logic              Rst,
  rst_sequencer_if.master  bus
);

  localparam int CNT_W = clog2_max(HOLD_CYCLES, STAGGER_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       IDX_LAST     = 4'(NUM_CH - 1);

  seq_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        idx;
  logic [NUM_CH-1:0] ch_rst;
  logic              done;
  logic              fault;
  logic [3:0]        fault_ch;

  logic              ready_cur;
  logic [NUM_CH-1:0] cur_mask;
  logic [NUM_CH-1:0] nxt_mask;

  // Decode the active domain without a variable-width bit select.
  always_comb begin
    ready_cur = 1'b0;
    cur_mask  = '0;
    nxt_mask  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx == 4'(i)) begin
        ready_cur   = bus.ChReady[i];
        cur_mask[i] = 1'b1;
      end
      if ((idx + 4'd1) == 4'(i)) begin
        nxt_mask[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst || bus.SoftRstReq) begin
      state    <= HOLD;
      cnt      <= '0;
      idx      <= '0;
      ch_rst   <= '1;
      done     <= 1'b0;
      fault    <= 1'b0;
      fault_ch <= '0;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            ch_rst <= ch_rst & ~cur_mask;
            state  <= WAIT_ACK;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_ACK: begin
          // Ack is tested before the timeout so a same-cycle ack still counts.
          if (ready_cur) begin
            if (idx == IDX_LAST) begin
              state <= RUN;
              done  <= 1'b1;
            end else begin
              state <= GAP;
              cnt   <= '0;
            end
          end else if (cnt == TIMEOUT_LAST) begin
            state    <= FAULT;
            ch_rst   <= '1;
            fault    <= 1'b1;
            fault_ch <= idx;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == STAGGER_LAST) begin
            idx    <= idx + 4'd1;
            ch_rst <= ch_rst & ~nxt_mask;
            state  <= WAIT_ACK;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RUN, FAULT: begin
        end
        default: begin
          state <= HOLD;
        end
      endcase
    end
  end

  assign bus.ChRst   = ch_rst;
  assign bus.Done    = done;
  assign bus.Fault   = fault;
  assign bus.FaultCh = fault_ch;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb/tb_rst_sequencer.sv - directed and random checks of rst_sequencer against an edge-timestamp model
module tb_rst_sequencer;

  localparam int N    = 3;
  localparam int HOLD = 4;
  localparam int STAG = 2;
  localparam int TMO  = 8;

  logic Clk = 1'b0;
  logic Rst = 1'b0;

  always #5 Clk = ~Clk;

  rst_sequencer_if #(.NUM_CH(N)) bus ();

  rst_sequencer #(
    .NUM_CH        (N),
    .HOLD_CYCLES   (HOLD),
    .STAGGER_CYCLES(STAG),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Model: each domain's release is a scheduled edge number, timeouts are release edge + TMO.
  int m_next_rel = 0;
  int m_rel_edge = 0;
  int m_ch       = 0;
  int m_released = 0;
  bit m_wait     = 1'b0;
  bit m_done     = 1'b0;
  bit m_fault    = 1'b0;
  int m_fch      = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    if (!Rst || bus.SoftRstReq) begin
      m_next_rel = cyc + HOLD;
      m_rel_edge = 0;
      m_ch       = 0;
      m_released = 0;
      m_wait     = 1'b0;
      m_done     = 1'b0;
      m_fault    = 1'b0;
      m_fch      = 0;
    end else if (m_done || m_fault) begin
    end else if (!m_wait) begin
      if (cyc == m_next_rel) begin
        m_released = m_ch + 1;
        m_rel_edge = cyc;
        m_wait     = 1'b1;
      end
    end else if (((bus.ChReady >> m_ch) & 1) != 0) begin
      if (m_ch == N - 1) begin
        m_done = 1'b1;
      end else begin
        m_ch       = m_ch + 1;
        m_next_rel = cyc + STAG;
        m_wait     = 1'b0;
      end
    end else if (cyc == m_rel_edge + TMO) begin
      m_fault    = 1'b1;
      m_fch      = m_ch;
      m_released = 0;
      m_wait     = 1'b0;
    end
  endtask

  task automatic tick();
    logic [N-1:0] exp_rst;
    @(posedge Clk);
    model_edge();
    cyc++;
    #1;
    for (int i = 0; i < N; i++) exp_rst[i] = (i >= m_released);
    check_val("ChRst",   32'(bus.ChRst),   32'(exp_rst));
    check_val("Done",    32'(bus.Done),    32'(m_done));
    check_val("Fault",   32'(bus.Fault),   32'(m_fault));
    check_val("FaultCh", 32'(bus.FaultCh), m_fch);
  endtask

  task automatic soft_pulse();
    bus.SoftRstReq = 1'b1;
    tick();
    bus.SoftRstReq = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    bit sparse;

    bus.SoftRstReq = 1'b0;
    bus.ChReady    = 3'b111;

    // Power-on: two edges of reset, then release with all domains ready.
    tick();
    tick();
    check_val("reset_chrst", 32'(bus.ChRst), 32'h7);
    Rst = 1'b1;
    for (int k = 0; k < 40 && !m_done; k++) tick();
    check_val("seq_done", 32'(bus.Done), 32'h1);
    check_val("seq_chrst", 32'(bus.ChRst), 32'h0);

    // Domain 1 never acks: timeout fault.
    bus.ChReady = 3'b101;
    soft_pulse();
    check_val("soft_from_run", 32'(bus.ChRst), 32'h7);
    for (int k = 0; k < 60 && !m_fault; k++) tick();
    check_val("fault_set", 32'(bus.Fault), 32'h1);
    check_val("fault_ch1", 32'(bus.FaultCh), 32'h1);
    for (int k = 0; k < 5; k++) tick();

    // Recover from FAULT with a soft reset.
    bus.ChReady = 3'b111;
    soft_pulse();
    check_val("fault_cleared", 32'(bus.Fault), 32'h0);
    for (int k = 0; k < 40 && !m_done; k++) tick();
    check_val("recover_done", 32'(bus.Done), 32'h1);

    // Block reset pulse while waiting on domain 2.
    bus.ChReady = 3'b011;
    soft_pulse();
    for (int k = 0; k < 40 && !(m_wait && m_ch == 2); k++) tick();
    check_val("reach_ch2", 32'(bus.ChRst), 32'h0);
    Rst = 1'b0;
    tick();
    Rst = 1'b1;
    check_val("mid_rst_chrst", 32'(bus.ChRst), 32'h7);
    bus.ChReady = 3'b111;
    for (int k = 0; k < 40 && !m_done; k++) tick();
    check_val("restart_done", 32'(bus.Done), 32'h1);

    // Domain 1 acks on the very edge its timeout would fire.
    bus.ChReady = 3'b001;
    soft_pulse();
    for (int k = 0; k < 40 && !(m_wait && m_ch == 1); k++) tick();
    check_val("reach_ch1", 32'(bus.ChRst), 32'h4);
    for (int k = 0; k < TMO - 1; k++) tick();
    bus.ChReady = 3'b011;
    tick();
    check_val("late_ack_nofault", 32'(bus.Fault), 32'h0);
    bus.ChReady = 3'b111;
    for (int k = 0; k < 40 && !m_done; k++) tick();
    check_val("late_ack_done", 32'(bus.Done), 32'h1);

    // Random acks, soft resets and block resets.
    sparse = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if ((k % 100) == 0) sparse = ~sparse;
      r = $urandom;
      if (sparse && $urandom_range(0, 5) != 0) r = 32'h0;
      bus.ChReady    = r[N-1:0];
      bus.SoftRstReq = ($urandom_range(0, 39) == 0);
      Rst            = ($urandom_range(0, 79) != 0);
      tick();
    end
    bus.SoftRstReq = 1'b0;
    Rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
